// File: rtl/entropy_word_collector.sv
// Entropy word collector: synchronizes the raw ring-oscillator bit, samples it
// on a divided strobe, runs a repetition-count health test, von Neumann
// debiases sample pairs and packs the surviving bits into WIDTH-bit words
// presented on a valid/ready handshake.
//
// Pair FSM states
//   state    | meaning
//   ST_EMPTY | no sample of the current pair held yet
//   ST_HALF  | first sample of the pair stored in first_q
module entropy_word_collector #(
  parameter int WIDTH        = 16,
  parameter int SAMPLE_DIV   = 4,
  parameter int REPEAT_LIMIT = 32
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             random_in,
  input  logic             enable,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             health_fail
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int REP_W = $clog2(REPEAT_LIMIT + 1);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {ST_EMPTY, ST_HALF} pair_state_e;

  pair_state_e      state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             prev_q, prev_d;
  logic             first_q, first_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             health_fail_q, health_fail_d;

  logic sample;
  logic run;
  logic strobe;
  logic emit;
  logic full;
  logic load;

  // Register all state; reset asserts asynchronously, releases on CLK.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_EMPTY;
      sync_q        <= '0;
      div_q         <= '0;
      rep_cnt_q     <= '0;
      prev_q        <= 1'b0;
      first_q       <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      health_fail_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      div_q         <= div_d;
      rep_cnt_q     <= rep_cnt_d;
      prev_q        <= prev_d;
      first_q       <= first_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      health_fail_q <= health_fail_d;
    end
  end

  // Next-state logic: strobe, health test, pair FSM, packing and handshake.
  always_comb begin
    sync_d        = {sync_q[0], random_in};
    state_d       = state_q;
    div_d         = div_q;
    rep_cnt_d     = rep_cnt_q;
    prev_d        = prev_q;
    first_d       = first_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    emit          = 1'b0;

    sample        = sync_q[1];
    run           = enable && !health_fail_q;
    strobe        = run && (div_q == DIV_W'(SAMPLE_DIV - 1));
    full          = (bit_cnt_q == CNT_W'(WIDTH));
    // The trip is decided from the registered count, so it lands one edge
    // after the limiting sample.
    health_fail_d = health_fail_q || (rep_cnt_q == REP_W'(REPEAT_LIMIT));
    // A full word moves out even in the cycle enable drops; it is complete.
    load          = full && (!out_valid_q || out_ready) && !health_fail_d;

    if (!run) begin
      div_d     = '0;
      rep_cnt_d = '0;
      prev_d    = 1'b0;
      state_d   = ST_EMPTY;
      first_d   = 1'b0;
      shift_d   = '0;
      bit_cnt_d = '0;
    end else begin
      div_d = strobe ? '0 : div_q + DIV_W'(1);
      if (strobe) begin
        // rep_cnt_q==0 means no previous sample since the last clear.
        if (rep_cnt_q == '0 || sample != prev_q)
          rep_cnt_d = REP_W'(1);
        else if (rep_cnt_q != REP_W'(REPEAT_LIMIT))
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        prev_d = sample;

        case (state_q)
          ST_EMPTY: begin
            first_d = sample;
            state_d = ST_HALF;
          end
          default: begin
            emit    = (sample != first_q);
            state_d = ST_EMPTY;
          end
        endcase
      end

      if (load)
        bit_cnt_d = '0;
      else if (emit && !full) begin
        shift_d   = {shift_q[WIDTH-2:0], first_q};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end

    if (load) begin
      out_data_d  = shift_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (health_fail_d)
      out_valid_d = 1'b0;
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign health_fail = health_fail_q;

endmodule

// File: tb/tb_entropy_word_collector.sv
// Directed bench for entropy_word_collector with one raw sample per clock.
module tb_entropy_word_collector;

  logic        CLK;
  logic        reset_n;
  logic        random_in;
  logic        enable;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        health_fail;

  int n_checks;
  int n_errors;
  bit stim[$];

  entropy_word_collector #(
    .WIDTH(16),
    .SAMPLE_DIV(1),
    .REPEAT_LIMIT(32)
  ) dut (
    .CLK(CLK),
    .reset_n(reset_n),
    .random_in(random_in),
    .enable(enable),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .health_fail(health_fail)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each data bit becomes a debiasing pair: 1 -> (1,0), 0 -> (0,1).
  task automatic push_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) begin
      stim.push_back(w[i]);
      stim.push_back(!w[i]);
    end
  endtask

  task automatic push_pair(input bit a, input bit b);
    stim.push_back(a);
    stim.push_back(b);
  endtask

  // Drive stim one bit per negedge. Bit i is sampled at the 3rd edge after its
  // drive; enable rises so that bit 0 is the first sample. Returns at the
  // negedge after the last bit's sampling edge.
  task automatic play(input bit hold_en, input bit en_now);
    if (!en_now) enable = 1'b0;
    for (int i = 0; i < stim.size(); i++) begin
      @(negedge CLK);
      random_in = stim[i];
      if (en_now && i == 0) reset_n = 1'b1;
      if (!en_now && i == 2) enable = 1'b1;
    end
    repeat (3) begin
      @(negedge CLK);
      random_in = ~random_in;
    end
    if (!hold_en) enable = 1'b0;
    stim.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      random_in = ~random_in;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b1;
    random_in = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_data", 32'(out_data), 32'd0);
    check_val("rst_hf", 32'(health_fail), 32'd0);
    repeat (3) @(negedge CLK);
    reset_n = 1'b1;

    // 1: all-ones word then all-zeros word
    for (int i = 0; i < 16; i++) push_pair(1'b1, 1'b0);
    play(1'b0, 1'b0);
    check_val("t1_not_yet", 32'(out_valid), 32'd0);
    @(negedge CLK);
    check_val("t1_valid", 32'(out_valid), 32'd1);
    check_val("t1_data", 32'(out_data), 32'hFFFF);
    consume();
    check_val("t1_drained", 32'(out_valid), 32'd0);
    check_val("t1_data_kept", 32'(out_data), 32'hFFFF);
    for (int i = 0; i < 16; i++) push_pair(1'b0, 1'b1);
    play(1'b0, 1'b0);
    @(negedge CLK);
    check_val("t1_valid2", 32'(out_valid), 32'd1);
    check_val("t1_data2", 32'(out_data), 32'h0000);
    consume();

    // 2: equal pairs only -> nothing emitted, no health trip
    for (int i = 0; i < 50; i++) begin
      push_pair(1'b0, 1'b0);
      push_pair(1'b1, 1'b1);
    end
    play(1'b0, 1'b0);
    @(negedge CLK);
    check_val("t2_valid", 32'(out_valid), 32'd0);
    check_val("t2_hf", 32'(health_fail), 32'd0);

    // 3: back-pressure with a second word waiting and excess bits dropped
    push_word(16'hA5C3);
    push_pair(1'b0, 1'b0);
    push_word(16'h3C5A);
    push_pair(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) push_pair(1'b1, 1'b0);
    play(1'b1, 1'b0);
    idle(4);
    check_val("t3_valid", 32'(out_valid), 32'd1);
    check_val("t3_data_a", 32'(out_data), 32'hA5C3);
    idle(5);
    check_val("t3_stable", 32'(out_data), 32'hA5C3);
    consume();
    check_val("t3_no_bubble", 32'(out_valid), 32'd1);
    check_val("t3_data_b", 32'(out_data), 32'h3C5A);
    consume();
    check_val("t3_drained", 32'(out_valid), 32'd0);
    check_val("t3_data_kept", 32'(out_data), 32'h3C5A);
    enable = 1'b0;
    idle(2);

    // 4: repetition trip with a word held, sticky until reset
    push_word(16'hFFFF);
    for (int i = 0; i < 32; i++) stim.push_back(1'b1);
    play(1'b1, 1'b0);
    check_val("t4_hf_pre", 32'(health_fail), 32'd0);
    check_val("t4_valid_pre", 32'(out_valid), 32'd1);
    check_val("t4_data_pre", 32'(out_data), 32'hFFFF);
    @(negedge CLK);
    check_val("t4_hf_trip", 32'(health_fail), 32'd1);
    check_val("t4_valid_drop", 32'(out_valid), 32'd0);
    idle(20);
    check_val("t4_hf_sticky", 32'(health_fail), 32'd1);
    check_val("t4_valid_off", 32'(out_valid), 32'd0);
    reset_n = 1'b0;
    @(negedge CLK);
    check_val("t4_hf_reset", 32'(health_fail), 32'd0);
    reset_n = 1'b1;
    enable  = 1'b0;
    idle(2);

    // 5: async reset mid-word, then a word built only from post-release bits
    push_word(16'h1234);
    play(1'b1, 1'b0);
    idle(10);
    check_val("t5_valid_pre", 32'(out_valid), 32'd1);
    check_val("t5_data_pre", 32'(out_data), 32'h1234);
    @(posedge CLK);
    #2 reset_n = 1'b0;
    #1;
    check_val("t5_rst_valid", 32'(out_valid), 32'd0);
    check_val("t5_rst_data", 32'(out_data), 32'd0);
    check_val("t5_rst_hf", 32'(health_fail), 32'd0);
    idle(3);
    push_word(16'h5A0F);
    play(1'b0, 1'b1);
    @(negedge CLK);
    check_val("t5_valid", 32'(out_valid), 32'd1);
    check_val("t5_data", 32'(out_data), 32'h5A0F);
    consume();

    // 6: enable dropped after 8 emitted bits discards the partial word
    for (int i = 0; i < 8; i++) push_pair(1'b1, 1'b0);
    play(1'b0, 1'b0);
    idle(3);
    check_val("t6_no_word", 32'(out_valid), 32'd0);
    push_word(16'h1357);
    play(1'b0, 1'b0);
    @(negedge CLK);
    check_val("t6_valid", 32'(out_valid), 32'd1);
    check_val("t6_data", 32'(out_data), 32'h1357);
    consume();
    check_val("t6_drained", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
